// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH shift-and-add multiplier.
// One start launches one product; fixed latency, one-cycle done pulse.
module shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   inA,
  input  logic [WIDTH-1:0]   inB,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [PW-1:0]   acc_q;
  logic [PW-1:0]   mcand_q;
  logic [WIDTH-1:0] mplr_q;
  logic [CW-1:0]   count_q;
  logic [PW-1:0]   product_q;

  logic [PW-1:0]   acc_d;
  logic [PW-1:0]   mcand_d;
  logic [WIDTH-1:0] mplr_d;
  logic [CW-1:0]   count_d;

  // Partial-product step: add the shifted multiplicand when the
  // current multiplier bit is set; the sum never exceeds 2*WIDTH bits.
  always_comb begin
    acc_d   = acc_q;
    if (mplr_q[0]) begin
      acc_d = acc_q + mcand_q;
    end
    mcand_d = mcand_q << 1;
    mplr_d  = mplr_q >> 1;
    count_d = count_q + CW'(1);
  end

  // Control FSM and datapath registers; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplr_q    <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q <= {{WIDTH{1'b0}}, inA};
            mplr_q  <= inB;
            acc_q   <= '0;
            count_q <= '0;
            state_q <= CALC;
          end
        end
        CALC: begin
          acc_q   <= acc_d;
          mcand_q <= mcand_d;
          mplr_q  <= mplr_d;
          count_q <= count_d;
          if (count_q == LAST) begin
            product_q <= acc_d;
            state_q   <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Status flags are pure decodes of the state register.
  always_comb begin
    ready = (state_q == IDLE);
    busy  = (state_q == CALC) || (state_q == DONE);
    done  = (state_q == DONE);
  end

  assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier (WIDTH=8).
// Hand-computed products, immediate assertions at each check.
module tb_shift_add_multiplier;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  inA;
  logic [7:0]  inB;
  logic        ready;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int total;
  int bad;

  shift_add_multiplier #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .inA     (inA),
    .inB     (inB),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Launch one op with a 1-cycle start and check the full window.
  task automatic run_op(input string tag,
                        input logic [7:0] a,
                        input logic [7:0] b,
                        input logic [15:0] prev,
                        input logic [15:0] exp);
    inA   = a;
    inB   = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    inA   = 8'h5A;
    inB   = 8'hC3;
    for (int c = 1; c <= 9; c++) begin
      chk({tag, " busy"}, 32'(busy), 32'd1);
      chk({tag, " ready"}, 32'(ready), 32'd0);
      chk({tag, " done"}, 32'(done), (c == 9) ? 32'd1 : 32'd0);
      chk({tag, " prod"}, 32'(product),
          (c == 9) ? 32'(exp) : 32'(prev));
      tick();
    end
    chk({tag, " ready end"}, 32'(ready), 32'd1);
    chk({tag, " done end"}, 32'(done), 32'd0);
    chk({tag, " prod end"}, 32'(product), 32'(exp));
  endtask

  initial begin
    int dones;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    start = 1'b0;
    inA   = '0;
    inB   = '0;

    // 1. reset
    tick();
    tick();
    rst = 1'b0;
    chk("rst ready", 32'(ready), 32'd1);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst prod", 32'(product), 32'h0000);

    // 2. 13 x 11 = 143
    run_op("t2", 8'd13, 8'd11, 16'h0000, 16'h008F);

    // 3. corner operands
    run_op("t3ff", 8'hFF, 8'hFF, 16'h008F, 16'hFE01);
    run_op("t3z", 8'h00, 8'hA5, 16'hFE01, 16'h0000);

    // 4. start while busy is ignored
    inA   = 8'd13;
    inB   = 8'd11;
    start = 1'b1;
    tick();
    start = 1'b0;
    dones = 0;
    for (int c = 1; c <= 9; c++) begin
      if (c == 3) begin
        start = 1'b1;
        inA   = 8'd2;
        inB   = 8'd2;
      end else if (c == 4) begin
        start = 1'b0;
      end
      if (done) dones++;
      chk("t4 done", 32'(done), (c == 9) ? 32'd1 : 32'd0);
      tick();
    end
    chk("t4 prod", 32'(product), 32'h008F);
    chk("t4 ready", 32'(ready), 32'd1);
    chk("t4 pulses", 32'(dones), 32'd1);

    // 5. reset mid-CALC aborts
    inA   = 8'd7;
    inB   = 8'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5 ready", 32'(ready), 32'd1);
    chk("t5 busy", 32'(busy), 32'd0);
    chk("t5 prod", 32'(product), 32'h0000);
    dones = 0;
    for (int c = 0; c < 10; c++) begin
      if (done) dones++;
      tick();
    end
    chk("t5 no done", 32'(dones), 32'd0);
    run_op("t5", 8'd7, 8'd9, 16'h0000, 16'h003F);

    // 6. start held high: back-to-back ops
    inA   = 8'd3;
    inB   = 8'd5;
    start = 1'b1;
    tick();
    inA = 8'd6;
    inB = 8'd7;
    for (int c = 1; c <= 19; c++) begin
      if (c == 11) start = 1'b0;
      chk("t6 done", 32'(done),
          (c == 9 || c == 19) ? 32'd1 : 32'd0);
      chk("t6 prod", 32'(product),
          (c < 9) ? 32'h003F :
          (c < 19) ? 32'h000F : 32'h002A);
      if (c == 10) chk("t6 ready", 32'(ready), 32'd1);
      tick();
    end
    chk("t6 idle", 32'(ready), 32'd1);
    chk("t6 final", 32'(product), 32'h002A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
